clip_round_pipe: RTL

- Pipelined, parametrised successor to the combinational clip stage.
- Per sample: right-shift by a runtime amount, round half-up, then saturate to BW_OUT under runtime signed/unsigned input and output modes.
- Adds a valid/ready stream handshake, per-sample clip flags and saturating clip-event counters.
- Sits between the sensor accumulator/filter output and narrower downstream consumers (FIFO, serializer).

---
 rtl/clip_round_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/clip_round_pipe.sv
// clip_round_pipe: two-stage shift, round-half-up and saturate stream stage
// with per-sample clip flags and saturating clip-event counters.
module clip_round_pipe #(
    parameter int BW_IN   = 16,
    parameter int BW_OUT  = 8,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_in_is_signed,
    input  logic               data_out_is_signed,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW_IN-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BW_OUT-1:0]  out_data,
    output logic [1:0]         out_clip,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   clip_up_cnt,
    output logic [CNT_W-1:0]   clip_lo_cnt
);
    localparam logic signed [BW_IN:0] S_MAX = {{(BW_IN-BW_OUT+2){1'b0}}, {(BW_OUT-1){1'b1}}};
    localparam logic signed [BW_IN:0] S_MIN = {{(BW_IN-BW_OUT+2){1'b1}}, {(BW_OUT-1){1'b0}}};
    localparam logic signed [BW_IN:0] U_MAX = {{(BW_IN-BW_OUT+1){1'b0}}, {BW_OUT{1'b1}}};
    localparam logic signed [BW_IN:0] U_MIN = '0;

    logic                    s1_valid, s1_os, s2_valid, s2_load, up, dn, xfer;
    logic signed [BW_IN:0]   x, r, s1_r, hi, lo;
    logic signed [BW_IN+1:0] t;
    logic [31:0]             s_amt;

    assign s2_load   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_load;
    assign out_valid = s2_valid;
    assign xfer      = out_valid & out_ready;

    // The extra LSB below x catches the last bit shifted out, which is the round-half-up increment.
    always_comb begin
        s_amt = 32'(shift) > 32'(BW_IN) ? 32'(BW_IN) : 32'(shift);
        x     = data_in_is_signed ? {in_data[BW_IN-1], in_data} : {1'b0, in_data};
        t     = $signed({x, 1'b0}) >>> s_amt;
        r     = t[BW_IN+1:1] + {{BW_IN{1'b0}}, t[0]};
    end

    always_comb begin
        hi = s1_os ? S_MAX : U_MAX;
        lo = s1_os ? S_MIN : U_MIN;
        up = s1_r > hi;
        dn = s1_r < lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_os    <= 1'b0;
            s1_r     <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_clip <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_r  <= r;
                    s1_os <= data_out_is_signed;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= up ? hi[BW_OUT-1:0] : dn ? lo[BW_OUT-1:0] : s1_r[BW_OUT-1:0];
                    out_clip <= {up, dn};
                end
            end
        end
    end

    // A clear that coincides with a counted transfer still records that transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_up_cnt <= '0;
            clip_lo_cnt <= '0;
        end else begin
            if (cnt_clr)
                clip_up_cnt <= CNT_W'(xfer & out_clip[1]);
            else if (xfer && out_clip[1] && !(&clip_up_cnt))
                clip_up_cnt <= clip_up_cnt + CNT_W'(1);
            if (cnt_clr)
                clip_lo_cnt <= CNT_W'(xfer & out_clip[0]);
            else if (xfer && out_clip[0] && !(&clip_lo_cnt))
                clip_lo_cnt <= clip_lo_cnt + CNT_W'(1);
        end
    end
endmodule
